// File: rtl/llc_cmd_dispatch.sv
// Front-end command stage: filters illegal trace opcodes, buffers legal ones in order,
// splits tag/index for the handlers and keeps saturating per-class request counters.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | accepting commands while the FIFO has room
// ST_BLOCK | clear (op 8) queued; intake stalled until it is dequeued
module llc_cmd_dispatch #(
   parameter int ADDR_W     = 32,
   parameter int OFFSET_W   = 6,
   parameter int INDEX_W    = 14,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 32,
   localparam int TAG_W     = ADDR_W - INDEX_W - OFFSET_W,
   localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [3:0]          cmd_op,
   input  logic [ADDR_W-1:0]   cmd_addr,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [3:0]          out_op,
   output logic [ADDR_W-1:0]   out_addr,
   output logic [TAG_W-1:0]    out_tag,
   output logic [INDEX_W-1:0]  out_index,
   output logic                err_pulse,
   output logic [LVL_W-1:0]    fifo_level,
   output logic [CNT_W-1:0]    cnt_reads,
   output logic [CNT_W-1:0]    cnt_writes,
   output logic [CNT_W-1:0]    cnt_snoops,
   output logic [CNT_W-1:0]    cnt_illegal
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [0:0] {ST_RUN, ST_BLOCK} state_t;

   state_t state, state_nxt;

   logic [3:0]        mem_op   [FIFO_DEPTH];
   logic [ADDR_W-1:0] mem_addr [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [LVL_W-1:0]  level;

   logic              legal, accept, push, pop, clear_stats;
   logic [3:0]        head_op;
   logic [ADDR_W-1:0] head_addr;

   assign legal       = (cmd_op <= 4'd9) && (cmd_op != 4'd7);
   assign accept      = cmd_valid && cmd_ready;
   assign push        = accept && legal;
   assign pop         = out_valid && out_ready;
   assign head_op     = mem_op[rd_ptr];
   assign head_addr   = mem_addr[rd_ptr];
   assign clear_stats = pop && (head_op == 4'd8);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      case (state)
         ST_RUN: begin
            cmd_ready = rst_n && (level < LVL_FULL);
            if (push && (cmd_op == 4'd8)) state_nxt = ST_BLOCK;
         end
         ST_BLOCK: begin
            if (clear_stats) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // Depth is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_op[wr_ptr]   <= cmd_op;
         mem_addr[wr_ptr] <= cmd_addr;
      end
   end

   assign fifo_level = level;
   assign out_valid  = (level != '0);
   assign out_op     = out_valid ? head_op   : '0;
   assign out_addr   = out_valid ? head_addr : '0;
   assign out_tag    = out_addr[ADDR_W-1 -: TAG_W];
   assign out_index  = out_addr[OFFSET_W +: INDEX_W];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   // A dequeued clear zeroes every counter and overrides any same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_pulse   <= 1'b0;
         cnt_reads   <= '0;
         cnt_writes  <= '0;
         cnt_snoops  <= '0;
         cnt_illegal <= '0;
      end else begin
         err_pulse <= accept && !legal;
         if (clear_stats) begin
            cnt_reads   <= '0;
            cnt_writes  <= '0;
            cnt_snoops  <= '0;
            cnt_illegal <= '0;
         end else begin
            if (pop && ((head_op == 4'd0) || (head_op == 4'd2)))
               cnt_reads <= sat_inc(cnt_reads);
            if (pop && (head_op == 4'd1))
               cnt_writes <= sat_inc(cnt_writes);
            if (pop && (head_op inside {[4'd3:4'd6]}))
               cnt_snoops <= sat_inc(cnt_snoops);
            if (accept && !legal)
               cnt_illegal <= sat_inc(cnt_illegal);
         end
      end
   end

endmodule
